// File: rtl/io_space_responder_pkg.sv
// io_space_responder_pkg: IO offsets, TCCR0 clock-select codes and prescaler tap decode
package io_space_responder_pkg;
  localparam int unsigned IO_PINB  = 'h16;
  localparam int unsigned IO_DDRB  = 'h17;
  localparam int unsigned IO_PORTB = 'h18;
  localparam int unsigned IO_TCNT0 = 'h32;
  localparam int unsigned IO_TCCR0 = 'h33;
  localparam int unsigned IO_TIFR  = 'h38;
  localparam int unsigned IO_TIMSK = 'h39;
  localparam logic [2:0] TCCR0_CS_STOP    = 3'd0;
  localparam logic [2:0] TCCR0_CS_DIV1    = 3'd1;
  localparam logic [2:0] TCCR0_CS_DIV8    = 3'd2;
  localparam logic [2:0] TCCR0_CS_DIV64   = 3'd3;
  localparam logic [2:0] TCCR0_CS_DIV256  = 3'd4;
  localparam logic [2:0] TCCR0_CS_DIV1024 = 3'd5;
  typedef struct packed {
    logic       en;
    logic [9:0] mask;
  } tick_sel_t;
  function automatic tick_sel_t tick_sel(input logic [2:0] cs);
    tick_sel.en   = cs >= TCCR0_CS_DIV1 && cs <= TCCR0_CS_DIV1024;
    tick_sel.mask = cs == TCCR0_CS_DIV8    ? 10'h007 :
                    cs == TCCR0_CS_DIV64   ? 10'h03f :
                    cs == TCCR0_CS_DIV256  ? 10'h0ff :
                    cs == TCCR0_CS_DIV1024 ? 10'h3ff : 10'h000;
  endfunction
endpackage

// File: rtl/io_space_responder_timer8.sv
// io_timer8: prescaled 8-bit timer holding TCNT0/TCCR0/TOV0; clk, reset (async active-low), write strobes + wdata in, tcnt/tccr/tov out
module io_timer8
  import io_space_responder_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       tcnt_we,
  input  logic       tccr_we,
  input  logic       tifr_we,
  input  logic [7:0] wdata,
  output logic [7:0] tcnt,
  output logic [2:0] tccr,
  output logic       tov
);
  logic [9:0] presc_q, presc_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic [2:0] tccr_q, tccr_d;
  logic       tov_q, tov_d;
  logic       tick, ovf;
  tick_sel_t  sel;
  always_comb begin
    sel     = tick_sel(tccr_q);
    tick    = sel.en && ((presc_q & sel.mask) == sel.mask);
    ovf     = tick && !tcnt_we && tcnt_q == 8'hff;
    presc_d = tccr_we ? 10'd0 : presc_q + 10'd1;
    tccr_d  = tccr_we ? wdata[2:0] : tccr_q;
    tcnt_d  = tcnt_we ? wdata : tick ? tcnt_q + 8'd1 : tcnt_q;
    tov_d   = ovf | (tov_q & ~(tifr_we & wdata[0]));
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      tccr_q  <= '0;
      tov_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      tccr_q  <= tccr_d;
      tov_q   <= tov_d;
    end
  end
  assign tcnt = tcnt_q;
  assign tccr = tccr_q;
  assign tov  = tov_q;
endmodule

// File: rtl/io_space_responder.sv
// io_space_responder: IO bus responder with GPIO port B and timer0; clk, reset (async active-low), bus_addr/bus_data/io_cs/io_we/io_oe bus, pin_in, port_out/port_dir/timer_irq
module io_space_responder
  import io_space_responder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IO_SIZE    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  input  logic                  io_cs,
  input  logic                  io_we,
  input  logic                  io_oe,
  input  logic [7:0]            pin_in,
  output logic [7:0]            port_out,
  output logic [7:0]            port_dir,
  output logic                  timer_irq
);
  localparam int OW = $clog2(IO_SIZE);
  logic                  wr, rd, in_io;
  logic [OW-1:0]         off;
  logic                  sel_ddr, sel_port, sel_tcnt, sel_tccr, sel_tifr, sel_timsk;
  logic [7:0]            wdata, tcnt;
  logic [2:0]            tccr;
  logic                  tov;
  logic [7:0]            ddr_q, ddr_d, port_q, port_d, sync1_q, sync2_q;
  logic                  timsk_q, timsk_d;
  logic [DATA_WIDTH-1:0] rd_data;
  assign wr    = (io_cs === 1'b1) && (io_we === 1'b1);
  assign rd    = (io_cs === 1'b1) && (io_oe === 1'b1) && (io_we === 1'b0);
  assign wdata = bus_data[7:0];
  always_comb begin
    in_io     = bus_addr < ADDR_WIDTH'(IO_SIZE);
    off       = bus_addr[OW-1:0];
    sel_ddr   = in_io && off == OW'(IO_DDRB);
    sel_port  = in_io && off == OW'(IO_PORTB);
    sel_tcnt  = in_io && off == OW'(IO_TCNT0);
    sel_tccr  = in_io && off == OW'(IO_TCCR0);
    sel_tifr  = in_io && off == OW'(IO_TIFR);
    sel_timsk = in_io && off == OW'(IO_TIMSK);
    ddr_d     = wr && sel_ddr ? wdata : ddr_q;
    port_d    = wr && sel_port ? wdata : port_q;
    timsk_d   = wr && sel_timsk ? wdata[0] : timsk_q;
    rd_data   = !in_io                  ? '0 :
                off == OW'(IO_PINB)     ? DATA_WIDTH'(sync2_q) :
                sel_ddr                 ? DATA_WIDTH'(ddr_q) :
                sel_port                ? DATA_WIDTH'(port_q) :
                sel_tcnt                ? DATA_WIDTH'(tcnt) :
                sel_tccr                ? DATA_WIDTH'(tccr) :
                sel_tifr                ? DATA_WIDTH'(tov) :
                sel_timsk               ? DATA_WIDTH'(timsk_q) : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ddr_q   <= '0;
      port_q  <= '0;
      timsk_q <= 1'b0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      ddr_q   <= ddr_d;
      port_q  <= port_d;
      timsk_q <= timsk_d;
      sync1_q <= pin_in;
      sync2_q <= sync1_q;
    end
  end
  io_timer8 u_timer (
    .clk     (clk),
    .reset   (reset),
    .tcnt_we (wr && sel_tcnt),
    .tccr_we (wr && sel_tccr),
    .tifr_we (wr && sel_tifr),
    .wdata   (wdata),
    .tcnt    (tcnt),
    .tccr    (tccr),
    .tov     (tov)
  );
  assign bus_data  = rd ? rd_data : 'z;
  assign port_out  = port_q;
  assign port_dir  = ddr_q;
  assign timer_irq = tov & timsk_q;
endmodule

// File: doc/io_space_responder.md
Name: io_space_responder

Overview:
- Responder side of the CPU's IO bus.
- Decodes io_cs/io_we/io_oe and the IO-relative bus_addr from the bus interface unit.
- Hosts an 8-bit GPIO port (PINB/DDRB/PORTB) and an 8-bit free-running timer with overflow flag and interrupt request.
- Services IN/OUT instructions: drives bus_data on reads, captures bus_data on writes.

Parameters:
- DATA_WIDTH, 8, register/bus data width.
- ADDR_WIDTH, 16, bus_addr width.
- IO_SIZE, 64, number of IO offsets decoded (0x00..0x3F).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- bus_addr  input  ADDR_WIDTH  IO offset, already relative to IO_START_ADDR.
- bus_data  inout  DATA_WIDTH  driven by block only during a qualified read, else high-Z.
- io_cs  input  1  IO chip select.
- io_we  input  1  write strobe, valid only when io_cs=1 (may be X otherwise).
- io_oe  input  1  output enable, valid only when io_cs=1 (may be X otherwise).
- pin_in  input  8  asynchronous external pin levels.
- port_out  output  8  PORTB value.
- port_dir  output  8  DDRB value (1 = output).
- timer_irq  output  1  TOV0 & TOIE0.

Behaviour:
- Qualified strobes:
  - wr = io_cs===1 && io_we===1.
  - rd = io_cs===1 && io_oe===1 && io_we===0.
  - X on we/oe while io_cs=0 must never cause a write or a bus drive.
- Register map (offset):
  - 0x16 PINB, read-only, synchronized pins.
  - 0x17 DDRB, R/W.
  - 0x18 PORTB, R/W.
  - 0x32 TCNT0, R/W.
  - 0x33 TCCR0, R/W, bits[2:0] used, others read 0.
  - 0x38 TIFR, bit0 TOV0, write-1-to-clear.
  - 0x39 TIMSK, bit0 TOIE0.
- Unmapped offsets and bus_addr >= IO_SIZE: reads return 0x00, writes ignored.
- Reads:
  - Combinational, zero latency.
  - bus_data = selected register while rd, else all-Z.
- Writes: take effect on the rising clk edge where wr=1; visible on outputs/reads the following cycle.
- pin_in: 2-flop synchronizer; PINB shows pin changes 2 clk edges later.
- Prescaler:
  - 10-bit counter, cleared by reset and by any TCCR0 write.
  - TCCR0[2:0] selects tick: 0 stopped, 1 every clk, 2 /8, 3 /64, 4 /256, 5 /1024, 6-7 stopped.
- Tick: TCNT0 += 1; 0xFF -> 0x00 sets TOV0 on the same edge.
- Simultaneous events:
  - CPU write to TCNT0 and tick in the same cycle: written value wins, no TOV0 set.
  - TOV0 set and W1C of TOV0 in the same cycle: set wins (TOV0=1).
  - TIFR write with bit0=0 leaves TOV0 unchanged.
- timer_irq: combinational AND of the registered TOV0 and TOIE0; stays high until cleared by W1C or TOIE0=0.
- Reset (asynchronous, any time, including mid-access):
  - DDRB, PORTB, TCNT0, TCCR0, TIFR, TIMSK, prescaler and synchronizer flops all reset to 0.
  - port_out=0x00, port_dir=0x00, timer_irq=0.
  - bus_data stays combinational: still driven if rd is asserted during reset, returning the reset values.

Decomposition:
- defines.vh gains the IO offsets as `IO_PINB, `IO_DDRB, `IO_PORTB, `IO_TCNT0, `IO_TCCR0, `IO_TIFR, `IO_TIMSK, plus the `TCCR0_CS_* clock-select codes.
- Sub-module io_timer8 holds the prescaler, TCNT0, TCCR0 and TOV0 set/clear logic. It takes write enables and data from the responder's decoder and returns tcnt, tccr and tov.
- Top-level io_space_responder contains address decode, the GPIO registers, the synchronizer and the read mux.

Test Plan:
- Reset low mid-operation with TCNT0=0x40 -> all registers 0x00, port_out=0x00, timer_irq=0 immediately (asynchronous); reading 0x32 after release returns 0x00.
- io_cs=1, we=1, addr 0x18, data 0xA5 -> port_out=0xA5 next cycle; read of 0x18 returns 0xA5. With io_cs=0 and we=X, bus_data stays Z and port_out is unchanged.
- pin_in 0x00->0x3C -> PINB read returns 0x00 after 1 edge and 0x3C after 2 edges. A write to 0x16 is ignored.
- TCNT0=0xFD, TCCR0=1, TIMSK=1 -> after 3 clks TCNT0=0x00, TIFR=0x01, timer_irq=1. Writing 0x01 to 0x38 clears irq next cycle; writing 0x00 leaves it set.
- TCCR0=2 -> TCNT0 increments once per 8 clks. A TCNT0 write of 0x10 on a tick cycle yields 0x10, not an increment. A W1C coinciding with overflow leaves TOV0=1.
- Reads of 0x00, 0x3F and bus_addr 0x0100 -> 0x00; a write of 0xFF there changes no register.
